arbiter_rr_4: RTL and testbench

//   Round-robin arbiter sharing one resource between 4 requesters. Selects a winner

---
 rtl/arbiter_pkg.sv | 30 +++
 rtl/decoder_2_4.sv | 14 +
 rtl/arbiter_rr_4.sv | 111 +++++++++++
 tb/tb_arbiter_rr_4.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   arb_state_t : FSM state (IDLE, GRANT)
//   N_REQ       : number of requesters
//   IDX_W       : width of a requester index
//   rr_pick     : round-robin winner search starting just after a pointer
package arbiter_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    // Scan candidates ptr+4 down to ptr+1. Each later hit overwrites an
    // earlier one, so the candidate closest after ptr wins. ptr+4 wraps to
    // ptr itself, which makes the last winner the lowest-priority choice.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] win;
        win = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                win = cand;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/decoder_2_4.sv
// 2-to-4 binary to one-hot decoder.
// Ports:
//   i_idx    in  2  binary index
//   o_onehot out 4  one-hot decode of i_idx
module decoder_2_4 (
    input  logic [1:0] i_idx,
    output logic [3:0] o_onehot
);

    always_comb begin
        o_onehot = 4'b0001 << i_idx;
    end

endmodule

// File: rtl/arbiter_rr_4.sv
// Round-robin arbiter sharing one resource between 4 requesters. A grant is
// held until the winner drops its request or MAX_HOLD cycles elapse, then
// the arbiter always spends one IDLE cycle before granting again.
// Ports:
//   i_clk         in  1  clock, all state on rising edge
//   i_rst_n       in  1  synchronous active-low reset
//   i_req         in  4  level request per requester
//   o_grant       out 4  one-hot grant, zero when no grant
//   o_grant_idx   out 2  binary index of grant (meaningful with o_grant_valid)
//   o_grant_valid out 1  high while a grant is held
//   o_timeout     out 1  one-cycle pulse after a forced revoke
module arbiter_rr_4
    import arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    output logic [3:0] o_grant,
    output logic [1:0] o_grant_idx,
    output logic       o_grant_valid,
    output logic       o_timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_ptr;
    logic             r_timeout;

    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_timeout_nxt;
    logic [IDX_W-1:0] w_win;
    logic [N_REQ-1:0] w_dec;
    logic             w_valid;

    assign w_win = rr_pick(i_req, r_ptr);

    // State register. Reset points the pointer at requester 3 so that
    // requester 0 is first in line after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_ptr     <= IDX_W'(N_REQ - 1);
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic. A release in the limit cycle takes precedence over
    // the revoke, so no timeout pulse is produced in that case.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_state_nxt = GRANT;
                    w_idx_nxt   = w_win;
                    w_ptr_nxt   = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!i_req[r_idx]) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_valid = (r_state == GRANT);

    decoder_2_4 u_dec (
        .i_idx    (r_idx),
        .o_onehot (w_dec)
    );

    assign o_grant       = w_dec & {N_REQ{w_valid}};
    assign o_grant_idx   = r_idx;
    assign o_grant_valid = w_valid;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_arbiter_rr_4.sv
// Self-checking bench for arbiter_rr_4 with MAX_HOLD=4. Directed vectors are
// checked against hand-computed values, and a behavioural model is compared
// against the DUT on every falling edge once reset has been applied.
module tb_arbiter_rr_4;

    localparam int MAX_HOLD = 4;

    logic       i_clk;
    logic       i_rst_n;
    logic [3:0] i_req;
    logic [3:0] o_grant;
    logic [1:0] o_grant_idx;
    logic       o_grant_valid;
    logic       o_timeout;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    arbiter_rr_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_req         (i_req),
        .o_grant       (o_grant),
        .o_grant_idx   (o_grant_idx),
        .o_grant_valid (o_grant_valid),
        .o_timeout     (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural model: who holds the grant, for how many visible cycles,
    // who won last, and whether the previous edge forced a revoke.
    bit mValid   = 0;
    int mIdx     = 0;
    int mHeld    = 0;
    int mPtr     = 3;
    bit mTimeout = 0;

    // Model update on each rising edge from the sampled request/reset.
    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            mValid   = 0;
            mIdx     = 0;
            mHeld    = 0;
            mPtr     = 3;
            mTimeout = 0;
        end else if (mValid) begin
            mTimeout = 0;
            if (!i_req[mIdx]) begin
                mValid = 0;
            end else if (mHeld == MAX_HOLD) begin
                mValid   = 0;
                mTimeout = 1;
            end else begin
                mHeld++;
            end
        end else begin
            mTimeout = 0;
            for (int step = 1; step <= 4; step++) begin
                int cand;
                cand = (mPtr + step) % 4;
                if (!mValid && i_req[cand]) begin
                    mValid = 1;
                    mIdx   = cand;
                    mPtr   = cand;
                    mHeld  = 1;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge i_clk) begin
        logic [3:0] expGrant;
        if (checkEn) begin
            expGrant = mValid ? (4'b0001 << mIdx) : 4'b0000;
            checks++;
            if (o_grant !== expGrant || o_grant_valid !== mValid ||
                o_grant_idx !== 2'(mIdx) || o_timeout !== mTimeout) begin
                errors++;
                $display("[TB] FAIL model t=%0t got grant=%b idx=%0d valid=%b to=%b, expected grant=%b idx=%0d valid=%b to=%b",
                         $time, o_grant, o_grant_idx, o_grant_valid, o_timeout,
                         expGrant, mIdx, mValid, mTimeout);
            end
        end
    end

    // Drive one vector at a falling edge and wait through one rising edge.
    task automatic applyStimulus(input logic [3:0] req, input logic rstN);
        i_req   = req;
        i_rst_n = rstN;
        @(negedge i_clk);
    endtask

    // Hand-computed expectation for the outputs after the last edge.
    task automatic checkOutput(input string name, input logic [3:0] expGrant,
                               input logic expValid, input logic expTimeout);
        checks++;
        if (o_grant !== expGrant || o_grant_valid !== expValid || o_timeout !== expTimeout) begin
            errors++;
            $display("[TB] FAIL %s got grant=%b valid=%b to=%b, expected grant=%b valid=%b to=%b",
                     name, o_grant, o_grant_valid, o_timeout, expGrant, expValid, expTimeout);
        end
    endtask

    logic [3:0] rrOrder [5];

    initial begin
        rrOrder[0] = 4'b0001;
        rrOrder[1] = 4'b0010;
        rrOrder[2] = 4'b0100;
        rrOrder[3] = 4'b1000;
        rrOrder[4] = 4'b0001;

        i_req   = 4'b1111;
        i_rst_n = 1'b0;
        @(negedge i_clk);

        // Reset with all requests high
        applyStimulus(4'b1111, 1'b0);
        checkEn = 1;
        applyStimulus(4'b1111, 1'b0);
        checkOutput("reset", 4'b0000, 1'b0, 1'b0);
        checks++;
        if (o_grant_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_idx got %0d expected 0", o_grant_idx);
        end

        // Single requester, then release
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_grant", 4'b0100, 1'b1, 1'b0);
        checks++;
        if (o_grant_idx !== 2'd2) begin
            errors++;
            $display("[TB] FAIL single_idx got %0d expected 2", o_grant_idx);
        end
        applyStimulus(4'b0000, 1'b1);
        checkOutput("single_release", 4'b0000, 1'b0, 1'b0);
        checks++;
        if (o_grant_idx !== 2'd2) begin
            errors++;
            $display("[TB] FAIL idx_hold got %0d expected 2", o_grant_idx);
        end

        // Round robin from a fresh pointer
        applyStimulus(4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 1'b1);
            checkOutput($sformatf("rr_grant%0d", i), rrOrder[i], 1'b1, 1'b0);
            applyStimulus(4'b1111 & ~rrOrder[i], 1'b1);
            checkOutput($sformatf("rr_idle%0d", i), 4'b0000, 1'b0, 1'b0);
        end

        // Hold limit: four granted cycles, then a one-cycle timeout pulse
        applyStimulus(4'b0010, 1'b1);
        checkOutput("hold_c1", 4'b0010, 1'b1, 1'b0);
        for (int i = 2; i <= MAX_HOLD; i++) begin
            applyStimulus(4'b0010, 1'b1);
            checkOutput($sformatf("hold_c%0d", i), 4'b0010, 1'b1, 1'b0);
        end
        applyStimulus(4'b0010, 1'b1);
        checkOutput("timeout_pulse", 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0011, 1'b1);
        checkOutput("after_timeout", 4'b0001, 1'b1, 1'b0);

        // Release in the limit cycle: no timeout pulse
        for (int i = 2; i <= MAX_HOLD; i++) begin
            applyStimulus(4'b0011, 1'b1);
            checkOutput($sformatf("limit_c%0d", i), 4'b0001, 1'b1, 1'b0);
        end
        applyStimulus(4'b0010, 1'b1);
        checkOutput("release_on_limit", 4'b0000, 1'b0, 1'b0);

        // Reset during a grant
        applyStimulus(4'b1000, 1'b1);
        checkOutput("pre_reset_grant", 4'b1000, 1'b1, 1'b0);
        applyStimulus(4'b1001, 1'b0);
        checkOutput("mid_reset", 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("post_reset_grant", 4'b0001, 1'b1, 1'b0);

        // Pointer must return to 3 on reset even after winner 0
        applyStimulus(4'b0011, 1'b0);
        checkOutput("reset2", 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0011, 1'b1);
        checkOutput("ptr_reset_grant", 4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0011, 1'b1);
        checkOutput("ptr_advance", 4'b0010, 1'b1, 1'b0);

        // Wrap from pointer 1: requester 3 ahead of 0
        applyStimulus(4'b1001, 1'b1);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("wrap_from1", 4'b1000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("wrap_to0", 4'b0001, 1'b1, 1'b0);

        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        checkEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
